pin_attempt_ctrl: RTL
=====================

Name: pin_attempt_ctrl

Overview:
- Sequencing controller wrapped around the PIN checker datapath.
- Gates keypad submits into the checker, paces digit entry and issues a checker reset before each attempt.
- Collects the correct/incorrect result and counts consecutive failures.
- After MAX_TRIES consecutive failures, enforces a timed lockout during which keypad input is ignored.

Parameters:
MAX_TRIES, 3, consecutive failures that trigger lockout (1..7)
LOCK_CYCLES, 64, lockout duration in clk cycles (>=2, <=65535)
GRANT_CYCLES, 16, cycles unlocked stays high after a correct PIN (>=1)
RESULT_TIMEOUT, 32, max cycles to wait for a checker result after the 4th digit
DIGIT_GAP, 3, cycles after a forwarded digit during which new submits are dropped

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
key_digit  in  2  keypad digit value
key_submit  in  1  keypad digit strobe, 1-cycle pulse
chk_digit  out  2  digit to checker, registered
chk_submit  out  1  1-cycle submit strobe to checker
chk_reset  out  1  1-cycle active-high reset pulse to checker
chk_correct  in  1  checker correct-result level
chk_incorrect  in  1  checker incorrect-result level
unlocked  out  1  access granted, held GRANT_CYCLES
locked_out  out  1  high for the whole lockout
fail_count  out  3  consecutive failures so far
timeout_err  out  1  1-cycle pulse when a result times out
busy  out  1  high whenever state != IDLE/ENTRY

Behaviour:
- Reset (reset=0, asynchronous): state=ARM, all outputs 0, fail_count=0, timers 0.
- States:
  - ARM: chk_reset=1 for exactly 1 cycle, digit count=0 -> ENTRY.
  - ENTRY: key_submit accepted only when the gap counter is 0.
    - Accepted submit: next cycle chk_submit=1, chk_digit=key_digit (latched at acceptance); gap counter loads DIGIT_GAP; digit count +1.
    - Dropped submits have no effect.
    - After the 4th accepted digit's chk_submit cycle -> WAIT.
  - WAIT: timer counts up from 0.
    - chk_correct=1 -> GRANT.
    - Else chk_incorrect=1 -> FAIL.
    - Both high in the same cycle: correct wins.
    - Timer reaches RESULT_TIMEOUT-1 with no result: timeout_err=1 for 1 cycle, -> FAIL.
  - GRANT: unlocked=1 for GRANT_CYCLES cycles, fail_count cleared to 0 on entry -> ARM.
  - FAIL: fail_count +1, saturating at 7.
    - New value >= MAX_TRIES -> LOCK.
    - Otherwise -> ARM.
    - Lasts 1 cycle.
  - LOCK: locked_out=1 for LOCK_CYCLES cycles, then fail_count=0 -> ARM.
  - IDLE is not used after reset. ARM is the entry point and busy reflects ARM/WAIT/GRANT/FAIL/LOCK.
- key_submit is ignored in every state except ENTRY, including the ARM cycle.
- unlocked and locked_out are never high together.
- The result inputs are levels. They are sampled only in WAIT, and stale levels are cleared by the chk_reset pulse in ARM.
- Reset during any state aborts the attempt immediately. No chk_submit or chk_reset pulse may appear while reset=0.
- Illegal state encodings recover to ARM on the next clock.

Test Plan:
- Release reset -> chk_reset=1 on the 1st clock only. Submits 2,2,1,0 spaced 4 cycles -> four chk_submit pulses each 1 cycle after the key pulse with matching chk_digit; chk_correct=1 -> unlocked=1 for exactly 16 cycles, fail_count=0, then chk_reset pulse.
- Submits on consecutive cycles -> only every 4th forwarded (DIGIT_GAP=3); digit count reaches 4 after 13 cycles of continuous pulses.
- Three attempts each ending in chk_incorrect -> fail_count 1,2,3; locked_out=1 for 64 cycles; submits during lockout produce no chk_submit; afterwards fail_count=0 and chk_reset pulses.
- Two failures then one success -> fail_count 1,2 then 0; locked_out never asserted.
- 4 digits, no result for 32 cycles -> timeout_err pulse on cycle 32 of WAIT, fail_count +1.
- chk_correct and chk_incorrect high in the same WAIT cycle -> GRANT. reset=0 asserted mid-ENTRY -> outputs 0 asynchronously, restart in ARM.

Source files
------------

// File: rtl/pin_attempt_if.sv
// pin_attempt_if: keypad, checker and status signals of the PIN attempt controller
`timescale 1ns/1ps
interface pin_attempt_if;
  logic [1:0] key_digit;
  logic       key_submit;
  logic [1:0] chk_digit;
  logic       chk_submit;
  logic       chk_reset;
  logic       chk_correct;
  logic       chk_incorrect;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] fail_count;
  logic       timeout_err;
  logic       busy;
  modport slave (
    input  key_digit, key_submit, chk_correct, chk_incorrect,
    output chk_digit, chk_submit, chk_reset, unlocked, locked_out, fail_count, timeout_err, busy
  );
  modport master (
    output key_digit, key_submit, chk_correct, chk_incorrect,
    input  chk_digit, chk_submit, chk_reset, unlocked, locked_out, fail_count, timeout_err, busy
  );
endinterface

// File: rtl/pin_attempt_ctrl.sv
// pin_attempt_ctrl: paces keypad digits into the PIN checker, collects results, counts failures and enforces lockout
`timescale 1ns/1ps
module pin_attempt_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 64,
  parameter int GRANT_CYCLES   = 16,
  parameter int RESULT_TIMEOUT = 32,
  parameter int DIGIT_GAP      = 3
) (
  input logic          clk,
  input logic          reset,
  pin_attempt_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, ENTRY, WAIT, GRANT, FAIL, LOCK} state_t;
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic [2:0]  cnt_q, cnt_d, fail_q, fail_d, fail_inc;
  logic [1:0]  digit_q, digit_d;
  logic        submit_q, submit_d, creset_q, creset_d, tout_q, tout_d, busy_q, busy_d, accept;
  assign accept   = state_q == ENTRY && bus.key_submit && gap_q == 8'd0 && cnt_q < 3'd4;
  assign fail_inc = fail_q == 3'd7 ? 3'd7 : fail_q + 3'd1;
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    gap_d    = gap_q != 8'd0 ? gap_q - 8'd1 : gap_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    digit_d  = digit_q;
    submit_d = 1'b0;
    creset_d = 1'b0;
    tout_d   = 1'b0;
    case (state_q)
      ARM: begin
        creset_d = 1'b1;
        cnt_d    = 3'd0;
        gap_d    = 8'd0;
        state_d  = ENTRY;
      end
      ENTRY: begin
        submit_d = accept;
        digit_d  = accept ? bus.key_digit : digit_q;
        gap_d    = accept ? 8'(DIGIT_GAP) : gap_d;
        cnt_d    = accept ? cnt_q + 3'd1 : cnt_q;
        state_d  = cnt_q == 3'd4 ? WAIT : ENTRY;
        timer_d  = 16'd0;
      end
      WAIT: begin
        // correct takes priority over incorrect when both levels are present
        if (bus.chk_correct) begin
          state_d = GRANT;
          timer_d = 16'd0;
          fail_d  = 3'd0;
        end else if (bus.chk_incorrect || timer_q == 16'(RESULT_TIMEOUT - 1)) begin
          state_d = FAIL;
          fail_d  = fail_inc;
          tout_d  = !bus.chk_incorrect;
        end
      end
      GRANT: state_d = timer_q == 16'(GRANT_CYCLES - 1) ? ARM : GRANT;
      FAIL: begin
        state_d = fail_q >= 3'(MAX_TRIES) ? LOCK : ARM;
        timer_d = 16'd0;
      end
      LOCK: begin
        state_d = timer_q == 16'(LOCK_CYCLES - 1) ? ARM : LOCK;
        fail_d  = timer_q == 16'(LOCK_CYCLES - 1) ? 3'd0 : fail_q;
      end
      default: state_d = ARM;
    endcase
    busy_d = !(state_d == IDLE || state_d == ENTRY);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARM;
      timer_q  <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      digit_q  <= '0;
      submit_q <= 1'b0;
      creset_q <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      digit_q  <= digit_d;
      submit_q <= submit_d;
      creset_q <= creset_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
    end
  end
  assign bus.chk_digit   = digit_q;
  assign bus.chk_submit  = submit_q;
  assign bus.chk_reset   = creset_q;
  assign bus.timeout_err = tout_q;
  assign bus.fail_count  = fail_q;
  assign bus.busy        = busy_q;
  assign bus.unlocked    = state_q == GRANT;
  assign bus.locked_out  = state_q == LOCK;
endmodule
